// File: rtl/lcd_controller_if.sv
// lcd_controller_if: groups the host write handshake and the HD44780-style
// 4-bit LCD bus of lcd_controller.
//   iWrite/iData/iRS : host write request, byte and register select
//   oReady           : controller idle and initialised
//   oLCD_E/RS/RW     : LCD enable strobe, register select, read/write (0)
//   oLCD_Data        : LCD data bus D[7:4]
// slave modport is used by the controller, master by whoever drives it.
interface lcd_controller_if;
  logic       iWrite;
  logic [7:0] iData;
  logic       iRS;
  logic       oReady;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_Data;

  modport slave (
    input  iWrite, iData, iRS,
    output oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data
  );

  modport master (
    output iWrite, iData, iRS,
    input  oReady, oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data
  );
endinterface

// File: rtl/lcd_controller.sv
// lcd_controller: power-up initialisation and byte writes to a character LCD
// in 4-bit mode. After reset it waits P_PWRUP cycles, sends the 4-bit-mode
// wake-up nibbles and the init command bytes, then idles with oReady=1.
// Ports:
//   Clock : single clock, rising edge
//   Reset : asynchronous, active-low
//   bus   : lcd_controller_if.slave (host handshake + LCD pins)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_PWRUP | power-up wait, P_PWRUP cycles
// S_SETUP | one cycle with data/RS driven and E low
// S_EHIGH | E high for P_E_PULSE cycles
// S_GAP   | E low for P_NIBBLE_GAP cycles between high and low nibble
// S_WAIT  | post-nibble/post-byte wait, length held in wait_tc_q
// S_IDLE  | initialised, oReady=1, accepts iWrite
module lcd_controller #(
  parameter int P_PWRUP      = 750000,
  parameter int P_INIT_LONG  = 205000,
  parameter int P_INIT_SHORT = 5000,
  parameter int P_E_PULSE    = 12,
  parameter int P_NIBBLE_GAP = 50,
  parameter int P_CMD_WAIT   = 2000,
  parameter int P_CLEAR_WAIT = 82000
) (
  input  logic             Clock,
  input  logic             Reset,
  lcd_controller_if.slave  bus
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int P_MAX = max2(max2(max2(P_PWRUP, P_INIT_LONG), max2(P_INIT_SHORT, P_E_PULSE)),
                              max2(max2(P_NIBBLE_GAP, P_CMD_WAIT), P_CLEAR_WAIT));
  localparam int CW = $clog2(P_MAX + 1);
  typedef logic [CW-1:0] cnt_t;

  // Terminal counts for an up-counter that starts at 0 on every step.
  localparam cnt_t C_PWRUP_TC = cnt_t'(P_PWRUP - 1);
  localparam cnt_t C_LONG_TC  = cnt_t'(P_INIT_LONG - 1);
  localparam cnt_t C_SHORT_TC = cnt_t'(P_INIT_SHORT - 1);
  localparam cnt_t C_E_TC     = cnt_t'(P_E_PULSE - 1);
  localparam cnt_t C_GAP_TC   = cnt_t'(P_NIBBLE_GAP - 1);
  localparam cnt_t C_CMD_TC   = cnt_t'(P_CMD_WAIT - 1);
  localparam cnt_t C_CLEAR_TC = cnt_t'(P_CLEAR_WAIT - 1);

  // Clear (0x01) and home (0x02) commands need the long execution wait.
  function automatic cnt_t byte_wait_tc(input logic rs, input logic [7:0] b);
    if (!rs && (b == 8'h01 || b == 8'h02)) return C_CLEAR_TC;
    return C_CMD_TC;
  endfunction

  typedef enum logic [2:0] {S_PWRUP, S_SETUP, S_EHIGH, S_GAP, S_WAIT, S_IDLE} state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  cnt_t       wait_tc_q, wait_tc_d;
  logic [3:0] step_q, step_d;     // next init step to load; 8 = init finished
  logic [7:0] byte_q, byte_d;     // init nibbles live in byte_q[7:4]
  logic       rs_q, rs_d;
  logic       is_byte_q, is_byte_d;
  logic       low_q, low_d;       // low nibble of a byte is being sent

  logic       load;
  logic [7:0] ld_byte;
  logic       ld_is_byte;
  cnt_t       ld_wait_tc;
  logic       drive;

  always_comb begin
    ld_byte    = 8'h00;
    ld_is_byte = 1'b0;
    ld_wait_tc = C_CMD_TC;
    case (step_q)
      4'd0:    begin ld_byte = 8'h30; ld_wait_tc = C_LONG_TC;  end
      4'd1:    begin ld_byte = 8'h30; ld_wait_tc = C_SHORT_TC; end
      4'd2:    ld_byte = 8'h30;
      4'd3:    ld_byte = 8'h20;
      4'd4:    begin ld_byte = 8'h28; ld_is_byte = 1'b1; end
      4'd5:    begin ld_byte = 8'h06; ld_is_byte = 1'b1; end
      4'd6:    begin ld_byte = 8'h0C; ld_is_byte = 1'b1; end
      4'd7:    begin ld_byte = 8'h01; ld_is_byte = 1'b1; end
      default: ld_byte = 8'h00;
    endcase
    if (ld_is_byte) ld_wait_tc = byte_wait_tc(1'b0, ld_byte);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + cnt_t'(1);
    wait_tc_d = wait_tc_q;
    step_d    = step_q;
    byte_d    = byte_q;
    rs_d      = rs_q;
    is_byte_d = is_byte_q;
    low_d     = low_q;
    load      = 1'b0;

    case (state_q)
      S_PWRUP: if (cnt_q == C_PWRUP_TC) load = 1'b1;
      S_SETUP: begin
        state_d = S_EHIGH;
        cnt_d   = '0;
      end
      S_EHIGH: if (cnt_q == C_E_TC) begin
        cnt_d   = '0;
        state_d = (is_byte_q && !low_q) ? S_GAP : S_WAIT;
      end
      S_GAP: if (cnt_q == C_GAP_TC) begin
        cnt_d   = '0;
        low_d   = 1'b1;
        state_d = S_SETUP;
      end
      S_WAIT: if (cnt_q == wait_tc_q) begin
        cnt_d = '0;
        if (step_q == 4'd8) state_d = S_IDLE;
        else                load    = 1'b1;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (bus.iWrite) begin
          state_d   = S_SETUP;
          byte_d    = bus.iData;
          rs_d      = bus.iRS;
          is_byte_d = 1'b1;
          low_d     = 1'b0;
          wait_tc_d = byte_wait_tc(bus.iRS, bus.iData);
        end
      end
      default: state_d = S_PWRUP;
    endcase

    if (load) begin
      state_d   = S_SETUP;
      cnt_d     = '0;
      byte_d    = ld_byte;
      is_byte_d = ld_is_byte;
      wait_tc_d = ld_wait_tc;
      rs_d      = 1'b0;
      low_d     = 1'b0;
      step_d    = step_q + 4'd1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_PWRUP;
      cnt_q     <= '0;
      wait_tc_q <= '0;
      step_q    <= 4'd0;
      byte_q    <= 8'h00;
      rs_q      <= 1'b0;
      is_byte_q <= 1'b0;
      low_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_tc_q <= wait_tc_d;
      step_q    <= step_d;
      byte_q    <= byte_d;
      rs_q      <= rs_d;
      is_byte_q <= is_byte_d;
      low_q     <= low_d;
    end
  end

  // Outputs decode registered state only, so the async reset clears them at once.
  assign drive         = (state_q == S_SETUP) || (state_q == S_EHIGH);
  assign bus.oReady    = (state_q == S_IDLE);
  assign bus.oLCD_E    = (state_q == S_EHIGH);
  assign bus.oLCD_RS   = drive & rs_q;
  assign bus.oLCD_RW   = 1'b0;
  assign bus.oLCD_Data = drive ? (low_q ? byte_q[3:0] : byte_q[7:4]) : 4'h0;

endmodule

// File: tb/tb_lcd_controller.sv
module tb_lcd_controller;
  localparam int TPW = 20, TIL = 10, TIS = 4, TE = 2, TG = 3, TCW = 5, TCL = 9;

  logic Clock;
  logic Reset;
  lcd_controller_if bus();

  lcd_controller #(
    .P_PWRUP(TPW), .P_INIT_LONG(TIL), .P_INIT_SHORT(TIS), .P_E_PULSE(TE),
    .P_NIBBLE_GAP(TG), .P_CMD_WAIT(TCW), .P_CLEAR_WAIT(TCL)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // E-pulse monitor: records data, RS, high length and stability of each pulse.
  logic [3:0] obs_d  [0:511];
  logic       obs_rs [0:511];
  int         obs_len[0:511];
  logic       obs_st [0:511];
  int         obs_n = 0;
  logic       in_pulse = 1'b0;
  logic [3:0] cur_d;
  logic       cur_rs;
  int         cur_len;
  logic       cur_st;

  always @(negedge Clock) begin
    if (!Reset) begin
      in_pulse = 1'b0;
    end else if (bus.oLCD_E) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        cur_d    = bus.oLCD_Data;
        cur_rs   = bus.oLCD_RS;
        cur_len  = 1;
        cur_st   = 1'b1;
      end else begin
        cur_len++;
        if (bus.oLCD_Data != cur_d || bus.oLCD_RS != cur_rs) cur_st = 1'b0;
      end
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      if (obs_n < 512) begin
        obs_d[obs_n]   = cur_d;
        obs_rs[obs_n]  = cur_rs;
        obs_len[obs_n] = cur_len;
        obs_st[obs_n]  = cur_st;
        obs_n++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pulse(input string tag, input int idx, input int d, input int rs);
    chk($sformatf("%s_p%0d_data", tag, idx), obs_d[idx], d);
    chk($sformatf("%s_p%0d_rs", tag, idx), obs_rs[idx], rs);
    chk($sformatf("%s_p%0d_len", tag, idx), obs_len[idx], TE);
    chk($sformatf("%s_p%0d_stable", tag, idx), obs_st[idx], 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_e"}, bus.oLCD_E, 0);
    chk({tag, "_rs"}, bus.oLCD_RS, 0);
    chk({tag, "_rw"}, bus.oLCD_RW, 0);
    chk({tag, "_data"}, bus.oLCD_Data, 0);
    chk({tag, "_ready"}, bus.oReady, 0);
  endtask

  // Releases Reset and checks the whole init sequence.
  task automatic init_check(input string tag);
    int n;
    int start;
    logic [3:0] exp_init [12];
    exp_init = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    start = obs_n;
    @(negedge Clock);
    Reset = 1'b1;
    n = 0;
    do begin
      @(posedge Clock); #1;
      n++;
    end while (!bus.oReady && n < 1000);
    chk({tag, "_ready_cycles"}, n, 116);
    chk({tag, "_pulse_count"}, obs_n - start, 12);
    for (int i = 0; i < 12; i++) chk_pulse(tag, start + i, exp_init[i], 0);
    chk({tag, "_rw"}, bus.oLCD_RW, 0);
  endtask

  // One write from IDLE; optional junk write request junk_at cycles after capture.
  task automatic run_write(input logic [7:0] d, input logic r, input int junk_at,
                           input logic [3:0] eh, input logic [3:0] el, input int eb,
                           input string tag);
    int busy;
    int start;
    start = obs_n;
    chk({tag, "_ready_before"}, bus.oReady, 1);
    bus.iWrite = 1'b1;
    bus.iData  = d;
    bus.iRS    = r;
    @(posedge Clock); #1;
    bus.iWrite = 1'b0;
    bus.iData  = ~d;
    bus.iRS    = ~r;
    busy = 0;
    while (!bus.oReady && busy < 100) begin
      busy++;
      if (junk_at != 0 && busy == junk_at) begin
        bus.iWrite = 1'b1;
        bus.iData  = 8'h4C;
      end else begin
        bus.iWrite = 1'b0;
      end
      @(posedge Clock); #1;
    end
    bus.iWrite = 1'b0;
    chk({tag, "_busy"}, busy, eb);
    chk({tag, "_pulse_count"}, obs_n - start, 2);
    chk_pulse(tag, start, eh, r);
    chk_pulse(tag, start + 1, el, r);
  endtask

  function automatic int model_busy(input logic [7:0] d, input logic r);
    int w;
    w = (!r && (d == 8'h01 || d == 8'h02)) ? TCL : TCW;
    return 2 + 2 * TE + TG + w;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         junk_at;
    logic [3:0] hi;
    logic [3:0] lo;
    int         busy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int hc, b2, n, start;
    logic [7:0] rd;
    logic rr;
    int rj;

    vecs[0] = '{8'h48, 1'b1, 0, 4'h4, 4'h8, 14};
    vecs[1] = '{8'h01, 1'b0, 0, 4'h0, 4'h1, 18};
    vecs[2] = '{8'h4F, 1'b1, 3, 4'h4, 4'hF, 14};
    vecs[3] = '{8'h02, 1'b0, 0, 4'h0, 4'h2, 18};
    vecs[4] = '{8'h01, 1'b1, 0, 4'h0, 4'h1, 14};
    vecs[5] = '{8'h03, 1'b0, 0, 4'h0, 4'h3, 14};
    vecs[6] = '{8'hC0, 1'b0, 5, 4'hC, 4'h0, 14};
    vecs[7] = '{8'h00, 1'b0, 0, 4'h0, 4'h0, 14};

    bus.iWrite = 1'b0;
    bus.iData  = 8'h00;
    bus.iRS    = 1'b0;
    Reset      = 1'b0;
    #1;
    chk_reset_outputs("por");
    #20;

    // Reset during init, then a full init.
    @(negedge Clock);
    Reset = 1'b1;
    repeat (50) @(posedge Clock);
    #1;
    Reset = 1'b0;
    #1;
    chk_reset_outputs("mid_init_rst");
    repeat (2) @(posedge Clock);
    init_check("init");

    for (int i = 0; i < 8; i++)
      run_write(vecs[i].data, vecs[i].rs, vecs[i].junk_at, vecs[i].hi, vecs[i].lo,
                vecs[i].busy, $sformatf("vec%0d", i));

    // Back-to-back with iWrite held high.
    start = obs_n;
    bus.iWrite = 1'b1;
    bus.iData  = 8'h48;
    bus.iRS    = 1'b1;
    @(posedge Clock); #1;
    bus.iData = 8'h4F;
    n = 0;
    while (!bus.oReady && n < 100) begin
      n++;
      @(posedge Clock); #1;
    end
    chk("b2b_busy1", n, 14);
    hc = 0;
    while (bus.oReady && hc < 100) begin
      hc++;
      @(posedge Clock); #1;
    end
    bus.iWrite = 1'b0;
    chk("b2b_ready_high_cycles", hc, 1);
    b2 = 0;
    while (!bus.oReady && b2 < 100) begin
      b2++;
      @(posedge Clock); #1;
    end
    chk("b2b_busy2", b2, 14);
    chk("b2b_pulse_count", obs_n - start, 4);
    chk_pulse("b2b", start, 4'h4, 1);
    chk_pulse("b2b", start + 1, 4'h8, 1);
    chk_pulse("b2b", start + 2, 4'h4, 1);
    chk_pulse("b2b", start + 3, 4'hF, 1);

    // Randomized writes against the formula model.
    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rd = 8'($urandom_range(1, 2));
      rr = 1'($urandom_range(0, 1));
      rj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
      run_write(rd, rr, rj, rd[7:4], rd[3:0], model_busy(rd, rr), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) @(posedge Clock);
      #1;
    end

    // Reset while E is high.
    bus.iWrite = 1'b1;
    bus.iData  = 8'h5A;
    bus.iRS    = 1'b1;
    @(posedge Clock); #1;
    bus.iWrite = 1'b0;
    n = 0;
    while (!bus.oLCD_E && n < 50) begin
      n++;
      @(posedge Clock); #1;
    end
    chk("rmb_saw_e", bus.oLCD_E, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk_reset_outputs("rmb");
    repeat (3) @(posedge Clock);
    #1;
    init_check("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
